// File: rtl/wm_control_panel.sv
// wm_control_panel
//
// Front-panel controller that sits in front of washing_machine. It turns the raw,
// bouncy START/PAUSE push-buttons and the door switch into a clean one-cycle start
// pulse and a pause level, and it watches done to release the door lock.
//
// Build option:
//   WM_BUZZER_EN  When defined, FINISH drives a buzzer for BUZZ_CYCLES cycles, and
//                 FINISH lasts max(UNLOCK_DELAY, BUZZ_CYCLES) cycles. When undefined,
//                 buzzer is tied low and there is no buzz counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synced samples needed to accept a button level (>=1)
//   UNLOCK_DELAY     cycles door_lock stays high in FINISH (>=1)
//   BUZZ_CYCLES      buzzer on-time in FINISH (exists only with WM_BUZZER_EN)
//
// Ports:
//   clk            in   system clock, rising edge
//   res            in   asynchronous active-low reset
//   btn_start_raw  in   raw START button, asynchronous, 1 = pressed
//   btn_pause_raw  in   raw PAUSE button, asynchronous, 1 = pressed
//   door_closed    in   door switch, synchronous to clk, 1 = closed
//   done           in   cycle-complete level from washing_machine
//   start          out  one-cycle start pulse to washing_machine
//   pause          out  pause level to washing_machine
//   door_lock      out  door solenoid lock
//   busy           out  high whenever the FSM is not in IDLE
//   err_door       out  one-cycle pulse: start refused or door opened mid-run
//   buzzer         out  finish tone
//
// FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a start press, door unlocked
//   ST_RUN    | cycle running, door locked
//   ST_PAUSED | cycle held (pause press or door opened), pause output high
//   ST_FINISH | done seen, door held locked for UNLOCK_DELAY, then unlocked

module wm_control_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
`ifdef WM_BUZZER_EN
    parameter int BUZZ_CYCLES     = 8,
`endif
    parameter int UNLOCK_DELAY    = 3
) (
    input  logic clk,
    input  logic res,
    input  logic btn_start_raw,
    input  logic btn_pause_raw,
    input  logic door_closed,
    input  logic done,
    output logic start,
    output logic pause,
    output logic door_lock,
    output logic busy,
    output logic err_door,
    output logic buzzer
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int UL_W = (UNLOCK_DELAY > 1) ? $clog2(UNLOCK_DELAY) : 1;
    localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [UL_W-1:0] UL_LOAD = UL_W'(UNLOCK_DELAY - 1);

    // ------------------------------------------------------------------
    // Button conditioning. Bit 0 = START, bit 1 = PAUSE.
    // ------------------------------------------------------------------
    logic [1:0]           raw;
    logic [1:0]           sync1;
    logic [1:0]           sync2;
    logic [1:0]           db_lvl;
    logic [1:0]           db_lvl_d;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           evt;
    logic                 start_evt;
    logic                 pause_evt;

    assign raw = {btn_pause_raw, btn_start_raw};

    // The counter tracks how many consecutive synced samples disagree with the
    // accepted level; any agreeing sample throws the partial count away.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only presses produce events; releases are deliberately silent.
    assign evt       = db_lvl & ~db_lvl_d;
    assign start_evt = evt[0];
    assign pause_evt = evt[1];

    // ------------------------------------------------------------------
    // Sequencing FSM. Every output is registered alongside the state.
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    logic            start_nxt;
    logic            pause_nxt;
    logic            lock_nxt;
    logic            busy_nxt;
    logic            err_nxt;
    logic            fin_done;
    logic [UL_W-1:0] unlock_cnt;
    logic [UL_W-1:0] unlock_nxt;

`ifdef WM_BUZZER_EN
    localparam int BZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BZ_W-1:0] BZ_LOAD = BZ_W'(BUZZ_CYCLES - 1);

    logic [BZ_W-1:0] buzz_cnt;
    logic [BZ_W-1:0] buzz_nxt;
    logic            buzzer_nxt;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= ST_IDLE;
            start      <= 1'b0;
            pause      <= 1'b0;
            door_lock  <= 1'b0;
            busy       <= 1'b0;
            err_door   <= 1'b0;
            unlock_cnt <= '0;
        end else begin
            state      <= state_nxt;
            start      <= start_nxt;
            pause      <= pause_nxt;
            door_lock  <= lock_nxt;
            busy       <= busy_nxt;
            err_door   <= err_nxt;
            unlock_cnt <= unlock_nxt;
        end
    end

`ifdef WM_BUZZER_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            buzz_cnt <= '0;
            buzzer   <= 1'b0;
        end else begin
            buzz_cnt <= buzz_nxt;
            buzzer   <= buzzer_nxt;
        end
    end
`else
    assign buzzer = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        err_nxt    = 1'b0;
        pause_nxt  = pause;
        lock_nxt   = door_lock;
        unlock_nxt = unlock_cnt;
        fin_done   = 1'b0;
`ifdef WM_BUZZER_EN
        buzz_nxt   = buzz_cnt;
        buzzer_nxt = buzzer;
`endif

        case (state)
            ST_IDLE: begin
                pause_nxt = 1'b0;
                lock_nxt  = 1'b0;
                if (start_evt) begin
                    if (door_closed) begin
                        start_nxt = 1'b1;
                        lock_nxt  = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (done) begin
                    pause_nxt  = 1'b0;
                    unlock_nxt = UL_LOAD;
                    state_nxt  = ST_FINISH;
`ifdef WM_BUZZER_EN
                    buzz_nxt   = BZ_LOAD;
                    buzzer_nxt = 1'b1;
`endif
                end else if (!door_closed) begin
                    err_nxt   = 1'b1;
                    pause_nxt = 1'b1;
                    state_nxt = ST_PAUSED;
                end else if (pause_evt) begin
                    pause_nxt = 1'b1;
                    state_nxt = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                pause_nxt = 1'b1;
                // Either button resumes; both in the same cycle count as one resume.
                if (start_evt || pause_evt) begin
                    if (door_closed) begin
                        pause_nxt = 1'b0;
                        state_nxt = ST_RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                pause_nxt = 1'b0;
                // Down-counters park at zero so the lock and the buzzer can end
                // independently; the state leaves only once both have expired.
                if (unlock_cnt == '0) begin
                    lock_nxt = 1'b0;
                end else begin
                    unlock_nxt = unlock_cnt - 1'b1;
                end
                fin_done = (unlock_cnt == '0);
`ifdef WM_BUZZER_EN
                if (buzz_cnt == '0) begin
                    buzzer_nxt = 1'b0;
                end else begin
                    buzz_nxt = buzz_cnt - 1'b1;
                end
                fin_done = fin_done && (buzz_cnt == '0);
`endif
                if (fin_done) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_wm_control_panel.sv
// Directed bench for wm_control_panel with default parameters
// (DEBOUNCE_CYCLES=4, UNLOCK_DELAY=3, BUZZ_CYCLES=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.

module tb_wm_control_panel;

    logic clk = 1'b0;
    logic res;
    logic btn_start_raw;
    logic btn_pause_raw;
    logic door_closed;
    logic done;
    logic start;
    logic pause;
    logic door_lock;
    logic busy;
    logic err_door;
    logic buzzer;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wm_control_panel dut (
        .clk           (clk),
        .res           (res),
        .btn_start_raw (btn_start_raw),
        .btn_pause_raw (btn_pause_raw),
        .door_closed   (door_closed),
        .done          (done),
        .start         (start),
        .pause         (pause),
        .door_lock     (door_lock),
        .busy          (busy),
        .err_door      (err_door),
        .buzzer        (buzzer)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return, the outputs show the cycle in which the press event acted
    // (the 7th edge that sampled the raw level high).
    task automatic press(input logic s, input logic p);
        btn_start_raw = s;
        btn_pause_raw = p;
        repeat (7) tick();
    endtask

    task automatic release_buttons();
        btn_start_raw = 1'b0;
        btn_pause_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        res = 1'b0;
        btn_start_raw = 1'b0;
        btn_pause_raw = 1'b0;
        door_closed = 1'b1;
        done = 1'b0;
        #12;
        vectors++;
        if ({start, pause, door_lock, busy, err_door, buzzer} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {start, pause, door_lock, busy, err_door, buzzer});
        end
        @(negedge clk);
        res = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({start, pause, door_lock, busy, err_door, buzzer} !== 6'b000000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected 000000",
                     {start, pause, door_lock, busy, err_door, buzzer});
        end
    endtask

    task automatic test_door_open_start();
        door_closed = 1'b0;
        press(1'b1, 1'b0);
        vectors++;
        if ({start, err_door, busy, door_lock} !== 4'b0100) begin
            miscompares++;
            $display("FAIL open_start_refused {start,err,busy,lock}: got %b expected 0100",
                     {start, err_door, busy, door_lock});
        end
        tick();
        vectors++;
        if ({start, err_door, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL open_start_single_err {start,err,busy}: got %b expected 000",
                     {start, err_door, busy});
        end
        release_buttons();
        door_closed = 1'b1;
    endtask

    task automatic test_start_bounce();
        int early;
        early = 0;
        for (int b = 0; b < 3; b++) begin
            btn_start_raw = 1'b1;
            tick();
            if (start) early++;
            btn_start_raw = 1'b0;
            tick();
            if (start) early++;
        end
        btn_start_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (start) early++;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL bounce_early_start: got %0d pulses expected 0", early);
        end
        tick();
        vectors++;
        if ({start, door_lock, busy, pause} !== 4'b1110) begin
            miscompares++;
            $display("FAIL bounce_start_latency {start,lock,busy,pause}: got %b expected 1110",
                     {start, door_lock, busy, pause});
        end
        tick();
        vectors++;
        if ({start, door_lock, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL start_single_pulse {start,lock,busy}: got %b expected 011",
                     {start, door_lock, busy});
        end
        release_buttons();
    endtask

    task automatic test_pause_resume();
        press(1'b0, 1'b1);
        vectors++;
        if ({pause, busy, door_lock, start} !== 4'b1110) begin
            miscompares++;
            $display("FAIL pause_press {pause,busy,lock,start}: got %b expected 1110",
                     {pause, busy, door_lock, start});
        end
        release_buttons();
        vectors++;
        if (pause !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_held: got %b expected 1", pause);
        end
        press(1'b0, 1'b1);
        vectors++;
        if ({pause, busy, door_lock, start} !== 4'b0110) begin
            miscompares++;
            $display("FAIL pause_resume {pause,busy,lock,start}: got %b expected 0110",
                     {pause, busy, door_lock, start});
        end
        tick();
        vectors++;
        if (start !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_no_start: got %b expected 0", start);
        end
        release_buttons();
    endtask

    task automatic test_door_open_run();
        door_closed = 1'b0;
        tick();
        vectors++;
        if ({err_door, pause} !== 2'b11) begin
            miscompares++;
            $display("FAIL run_door_open {err,pause}: got %b expected 11", {err_door, pause});
        end
        tick();
        vectors++;
        if ({err_door, pause} !== 2'b01) begin
            miscompares++;
            $display("FAIL run_door_open_next {err,pause}: got %b expected 01", {err_door, pause});
        end
        press(1'b1, 1'b0);
        vectors++;
        if ({err_door, pause, start} !== 3'b110) begin
            miscompares++;
            $display("FAIL paused_open_press {err,pause,start}: got %b expected 110",
                     {err_door, pause, start});
        end
        tick();
        vectors++;
        if ({err_door, pause} !== 2'b01) begin
            miscompares++;
            $display("FAIL paused_open_press_next {err,pause}: got %b expected 01",
                     {err_door, pause});
        end
        release_buttons();
        door_closed = 1'b1;
        press(1'b1, 1'b0);
        vectors++;
        if ({pause, busy, err_door, start} !== 4'b0100) begin
            miscompares++;
            $display("FAIL closed_resume {pause,busy,err,start}: got %b expected 0100",
                     {pause, busy, err_door, start});
        end
        release_buttons();
    endtask

    task automatic test_done_unlock();
        logic [2:0] exp;
        done = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                done = 1'b0;
                vectors++;
                if (pause !== 1'b0) begin
                    miscompares++;
                    $display("FAIL finish_pause: got %b expected 0", pause);
                end
            end
`ifdef WM_BUZZER_EN
            exp = {k <= 3, k <= 8, k <= 8};
`else
            exp = {k <= 3, k <= 3, 1'b0};
`endif
            vectors++;
            if ({door_lock, busy, buzzer} !== exp) begin
                miscompares++;
                $display("FAIL finish_cycle%0d {lock,busy,buzzer}: got %b expected %b",
                         k, {door_lock, busy, buzzer}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        press(1'b1, 1'b0);
        vectors++;
        if ({start, door_lock, busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL restart {start,lock,busy}: got %b expected 111",
                     {start, door_lock, busy});
        end
        release_buttons();
        @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        vectors++;
        if ({start, pause, door_lock, busy, err_door, buzzer} !== 6'b000000) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %b expected 000000",
                     {start, pause, door_lock, busy, err_door, buzzer});
        end
        #2;
        res = 1'b1;
        tick();
        press(1'b1, 1'b0);
        vectors++;
        if ({start, door_lock, busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL start_after_reset {start,lock,busy}: got %b expected 111",
                     {start, door_lock, busy});
        end
        release_buttons();
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1);
        vectors++;
        if ({pause, start} !== 2'b10) begin
            miscompares++;
            $display("FAIL run_both {pause,start}: got %b expected 10", {pause, start});
        end
        release_buttons();
        press(1'b1, 1'b1);
        vectors++;
        if ({pause, start, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL paused_both {pause,start,busy}: got %b expected 001",
                     {pause, start, busy});
        end
        release_buttons();
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (12) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_idle: got %b expected 0", busy);
        end
        press(1'b1, 1'b1);
        vectors++;
        if ({start, pause, door_lock} !== 3'b101) begin
            miscompares++;
            $display("FAIL idle_both {start,pause,lock}: got %b expected 101",
                     {start, pause, door_lock});
        end
        release_buttons();
    endtask

    initial begin
        test_reset();
        test_door_open_start();
        test_start_bounce();
        test_pause_resume();
        test_door_open_run();
        test_done_unlock();
        test_reset_mid_run();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
